// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam int unsigned LLC_W = 8;

  // Saturating increment for the lock-loss counter.
  function automatic logic [LLC_W-1:0] sat_inc(input logic [LLC_W-1:0] v);
    logic [LLC_W-1:0] r;
    if (v == {LLC_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(LLC_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-high reset.
module sync_2ff (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: reset pulse, lock wait with timeout/retry, stability
// qualification, run monitoring with lock-loss counting, and a latched fault.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned AREST_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic                               inclk0,
  input  logic                               reset,
  input  logic                               pll_locked,
  input  logic                               restart,
  output logic                               pll_areset,
  output logic                               run_reset,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [LLC_W-1:0]                   lock_loss_count,
  output logic [2:0]                         state
);

  localparam int unsigned MAX_AL = (AREST_CYCLES > LOCK_TIMEOUT) ? AREST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_C  = (MAX_AL > STABLE_CYCLES) ? MAX_AL : STABLE_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAX_C) + 1;
  localparam int unsigned RC_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] AREST_LAST  = CNT_W'(AREST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [RC_W-1:0]  RC_ONE      = RC_W'(1);
  localparam logic [RC_W-1:0]  RC_MAX      = RC_W'(MAX_RETRIES);

  logic             lk_s;
  logic             enter_s;
  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RC_W-1:0]  retry_q, retry_d;
  logic [LLC_W-1:0] llc_q, llc_d;
  logic             areset_q, areset_d;
  logic             run_reset_q, run_reset_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  sync_2ff u_lk_sync (
    .clk_i   (inclk0),
    .reset_i (reset),
    .d_i     (pll_locked),
    .q_o     (lk_s)
  );

  // State, counters and registered output decodes.
  always_ff @(posedge inclk0) begin
    if (reset) begin
      state_q     <= RST_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      llc_q       <= '0;
      areset_q    <= 1'b1;
      run_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      llc_q       <= llc_d;
      areset_q    <= areset_d;
      run_reset_q <= run_reset_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state, retry/loss bookkeeping and the shared cycle counter.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    llc_d   = llc_q;
    enter_s = 1'b0;
    if (restart) begin
      state_d = RST_PLL;
      retry_d = '0;
      enter_s = 1'b1;
    end else begin
      case (state_q)
        RST_PLL: begin
          if (cnt_q == AREST_LAST) begin
            state_d = WAIT_LOCK;
            enter_s = 1'b1;
          end else begin
            state_d = RST_PLL;
          end
        end
        WAIT_LOCK: begin
          if (lk_s) begin
            state_d = STABLE;
            enter_s = 1'b1;
          end else if (cnt_q == TIMEOUT_LAST) begin
            enter_s = 1'b1;
            if (retry_q < RC_MAX) begin
              retry_d = retry_q + RC_ONE;
              state_d = RST_PLL;
            end else begin
              state_d = FAULT;
            end
          end else begin
            state_d = WAIT_LOCK;
          end
        end
        STABLE: begin
          // A drop on the completing cycle still counts as a drop.
          if (!lk_s) begin
            state_d = WAIT_LOCK;
            enter_s = 1'b1;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            retry_d = '0;
            enter_s = 1'b1;
          end else begin
            state_d = STABLE;
          end
        end
        RUN: begin
          if (!lk_s) begin
            state_d = RST_PLL;
            llc_d   = sat_inc(llc_q);
            enter_s = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = RST_PLL;
          enter_s = 1'b1;
        end
      endcase
    end

    if (enter_s) begin
      cnt_d = '0;
    end else if ((state_q == RST_PLL) || (state_q == WAIT_LOCK) || (state_q == STABLE)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output decodes taken from the next state so they align with state_q.
  always_comb begin
    areset_d    = (state_d == RST_PLL) || (state_d == FAULT);
    run_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
  end

  assign pll_areset      = areset_q;
  assign run_reset       = run_reset_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = llc_q;
  assign state           = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboarded bench: directed scenarios plus random lock noise, checked every
// cycle against a phase/elapsed-time reference model.
module tb_pll_lock_sequencer;

  localparam int A  = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 2;

  logic       inclk0 = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_areset, run_reset, ready, fault;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  pll_lock_sequencer #(
    .AREST_CYCLES  (A),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .MAX_RETRIES   (MR)
  ) dut (
    .inclk0          (inclk0),
    .reset           (reset),
    .pll_locked      (pll_locked),
    .restart         (restart),
    .pll_areset      (pll_areset),
    .run_reset       (run_reset),
    .ready           (ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count),
    .state           (state)
  );

  always #5 inclk0 = ~inclk0;

  typedef struct {
    int          cyc;
    logic [16:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  // Reference model: phase number, cycles spent in phase, and the lock history.
  int ph = 0, t = 0, retries = 0, losses = 0;
  bit h0 = 1'b0, h1 = 1'b0;

  always @(posedge inclk0) cyc <= cyc + 1;

  function automatic logic [16:0] expected_outputs();
    logic [2:0] s;
    logic [1:0] r;
    logic [7:0] l;
    s = 3'(ph);
    r = 2'(retries);
    l = 8'(losses);
    return {s, 1'((ph == 0) || (ph == 4)), 1'(ph != 3), 1'(ph == 3), 1'(ph == 4), r, l};
  endfunction

  task automatic model_step(input bit rst, input bit rs, input bit lkin);
    bit lk;
    if (rst) begin
      ph = 0; t = 0; retries = 0; losses = 0; h0 = 1'b0; h1 = 1'b0;
    end else begin
      lk = h1;
      h1 = h0;
      h0 = lkin;
      if (rs) begin
        ph = 0; t = 0; retries = 0;
      end else begin
        case (ph)
          0: begin
            t++;
            if (t == A) begin ph = 1; t = 0; end
          end
          1: begin
            if (lk) begin
              ph = 2; t = 0;
            end else begin
              t++;
              if (t == LT) begin
                if (retries < MR) begin retries++; ph = 0; end
                else ph = 4;
                t = 0;
              end
            end
          end
          2: begin
            if (!lk) begin
              ph = 1; t = 0;
            end else begin
              t++;
              if (t == SC) begin ph = 3; t = 0; retries = 0; end
            end
          end
          3: begin
            if (!lk) begin
              if (losses < 255) losses++;
              ph = 0; t = 0;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic drive(input bit rst, input bit rs, input bit lk);
    exp_t e;
    @(posedge inclk0);
    #1;
    reset = rst;
    restart = rs;
    pll_locked = lk;
    model_step(rst, rs, lk);
    e.cyc = cyc + 1;
    e.v = expected_outputs();
    sb.push_back(e);
  endtask

  task automatic run(input int n, input bit rst, input bit rs, input bit lk);
    repeat (n) drive(rst, rs, lk);
  endtask

  // Monitor: pops the expectation belonging to the edge just taken.
  always @(negedge inclk0) begin : monitor
    exp_t e;
    logic [16:0] got;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL stale_expectation cyc=%0d actual=missed required=%h", e.cyc, e.v);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      got = {state, pll_areset, run_reset, ready, fault, retry_count, lock_loss_count};
      n_chk++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d actual st=%0d ar=%b rr=%b rdy=%b flt=%b rc=%0d llc=%0d required st=%0d ar=%b rr=%b rdy=%b flt=%b rc=%0d llc=%0d",
                 cyc, got[16:14], got[13], got[12], got[11], got[10], got[9:8], got[7:0],
                 e.v[16:14], e.v[13], e.v[12], e.v[11], e.v[10], e.v[9:8], e.v[7:0]);
      end else begin
        n_pass++;
      end
    end
  end

  initial begin
    bit lk_cur;
    // Reset and clean bring-up.
    run(3, 1'b1, 1'b0, 1'b0);
    run(10, 1'b0, 1'b0, 1'b0);
    run(30, 1'b0, 1'b0, 1'b1);
    // One-cycle glitch mid-STABLE.
    run(1, 1'b0, 1'b1, 1'b1);
    run(8, 1'b0, 1'b0, 1'b1);
    run(1, 1'b0, 1'b0, 1'b0);
    run(30, 1'b0, 1'b0, 1'b1);
    // Timeouts to FAULT, then FAULT holds with lock present.
    run(120, 1'b0, 1'b0, 1'b0);
    run(6, 1'b0, 1'b0, 1'b1);
    // Recovery via restart.
    run(1, 1'b0, 1'b1, 1'b1);
    run(30, 1'b0, 1'b0, 1'b1);
    // Lock losses in RUN, then saturation.
    repeat (3) begin
      run(2, 1'b0, 1'b0, 1'b0);
      run(25, 1'b0, 1'b0, 1'b1);
    end
    repeat (260) begin
      run(1, 1'b0, 1'b0, 1'b0);
      run(16, 1'b0, 1'b0, 1'b1);
    end
    run(4, 1'b0, 1'b0, 1'b1);
    // Reset together with restart mid-STABLE.
    run(1, 1'b0, 1'b1, 1'b1);
    run(7, 1'b0, 1'b0, 1'b1);
    run(1, 1'b1, 1'b1, 1'b1);
    run(3, 1'b0, 1'b0, 1'b1);
    // Restart swept across the STABLE completion edge.
    for (int off = 0; off < 20; off++) begin
      run(1, 1'b0, 1'b1, 1'b1);
      run(off, 1'b0, 1'b0, 1'b1);
      run(1, 1'b0, 1'b1, 1'b1);
      run(3, 1'b0, 1'b0, 1'b1);
    end
    // Random lock noise with sparse restart and reset.
    lk_cur = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) lk_cur = ~lk_cur;
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) == 0), lk_cur);
    end
    repeat (3) @(posedge inclk0);
    @(negedge inclk0);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
